rv32i_mem_arbiter: RTL and testbench

Arbitrates a single-port instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the 5-stage RV32I core. Serialises requests into one outstanding memory transaction, routes the response back, and raises per-port stall signals. Aging prevents fetch starvation, a flush drops stale fetch responses, and a timeout converts a hung memory into an error response. Sits between the pipeline and the memory inside the core, clocked by CPU_CLK.

---
 rtl/rv32i_mem_pkg.sv | 26 ++
 rtl/rv32i_mem_arbiter_if.sv | 60 ++++++
 rtl/rv32i_mem_timeout.sv | 28 ++
 rtl/rv32i_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared types and defaults for the RV32I IF/MEM memory arbiter.
// Pulled in by the arbiter top, its interface and its timeout counter.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_TIMEOUT    = 16;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter. The arbiter uses the
// slave view; the pipeline/memory environment uses the master view.
interface rv32i_mem_arbiter_if
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;
  logic              if_stall;

  // load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_stall;

  logic              err;

  // memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_rdata, mem_rvalid,
    output if_rdata, if_rvalid, if_stall,
    output d_rdata, d_rvalid, d_stall,
    output err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_rdata, mem_rvalid,
    input  if_rdata, if_rvalid, if_stall,
    input  d_rdata, d_rvalid, d_stall,
    input  err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/rv32i_mem_timeout.sv
// Loadable wait counter: cleared by i_load, counts while i_en, and holds at
// TIMEOUT where o_expire is raised.
module rv32i_mem_timeout
  import rv32i_mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic srst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = cnt_w(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (srst || i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter between IF (fetch) and MEM (load/store): one
// outstanding transaction, aging against fetch starvation, flush and timeout.
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic               CPU_CLK,
  input  logic               CPU_RST,
  rv32i_mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int SC_W = cnt_w(STARVE_MAX);

  state_e            r_state;
  owner_e            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_mem_req;
  logic              r_drop;
  logic              r_err;
  logic [SC_W-1:0]   r_starve_cnt;

  logic w_if_valid;
  logic w_any_req;
  logic w_starved;
  logic w_grant_if;
  logic w_expire;
  logic w_done;
  logic w_if_resp;
  logic w_d_resp;

  rv32i_mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (CPU_CLK),
    .srst     (CPU_RST),
    .i_load   (r_state == ISSUE),
    .i_en     (r_state == WAIT),
    .o_expire (w_expire)
  );

  // A flush in the arbitration cycle withdraws the fetch before it can win.
  assign w_if_valid = bus.if_req & ~bus.if_flush;
  assign w_any_req  = w_if_valid | bus.d_req;
  assign w_starved  = (r_starve_cnt == SC_W'(STARVE_MAX));
  assign w_grant_if = w_if_valid & (~bus.d_req | w_starved);

  assign w_done    = (r_state == WAIT) & (bus.mem_rvalid | w_expire);
  assign w_if_resp = w_done & (r_owner == OWN_IF) & ~r_drop & ~bus.if_flush;
  assign w_d_resp  = w_done & (r_owner == OWN_D);

  // Response data is the memory word on a real ack and zero on a timeout.
  assign bus.if_rvalid = w_if_resp;
  assign bus.if_rdata  = (w_if_resp & bus.mem_rvalid) ? bus.mem_rdata : '0;
  assign bus.d_rvalid  = w_d_resp;
  assign bus.d_rdata   = (w_d_resp & bus.mem_rvalid) ? bus.mem_rdata : '0;

  assign bus.if_stall = bus.if_req & ~w_if_resp;
  assign bus.d_stall  = bus.d_req & ~w_d_resp;
  assign bus.err      = r_err;

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_be    = r_be;

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IF;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_mem_req    <= 1'b0;
      r_drop       <= 1'b0;
      r_err        <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_mem_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.if_req) begin
            r_starve_cnt <= '0;
          end
          if (w_any_req) begin
            r_state   <= ISSUE;
            r_mem_req <= 1'b1;
            if (w_grant_if) begin
              r_owner      <= OWN_IF;
              r_addr       <= bus.if_addr;
              r_we         <= 1'b0;
              r_wdata      <= '0;
              r_be         <= '1;
              r_starve_cnt <= '0;
            end else begin
              r_owner <= OWN_D;
              r_addr  <= bus.d_addr;
              r_we    <= bus.d_we;
              r_wdata <= bus.d_wdata;
              r_be    <= bus.d_be;
              if (bus.if_req && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + SC_W'(1);
              end
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
          if (r_owner == OWN_IF && bus.if_flush) begin
            r_drop <= 1'b1;
          end
        end
        WAIT: begin
          if (r_owner == OWN_IF && bus.if_flush) begin
            r_drop <= 1'b1;
          end
          // Completion wins over a same-cycle flush: drop never outlives a transaction.
          if (w_done) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
            if (!bus.mem_rvalid) begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: reset, back-to-back D/IF, aging,
// flush, timeout and reset-during-WAIT, each step checked by assertion.
module tb_rv32i_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rv32i_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rv32i_mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4),
    .TIMEOUT    (16)
  ) dut (
    .CPU_CLK (clk),
    .CPU_RST (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h40;
    bus.if_flush   = 1'b0;
    bus.d_req      = 1'b1;
    bus.d_we       = 1'b0;
    bus.d_addr     = 32'h100;
    bus.d_wdata    = 32'h0;
    bus.d_be       = 4'hF;
    bus.mem_rdata  = 32'h0;
    bus.mem_rvalid = 1'b0;

    // reset held two cycles with both requests pending
    repeat (2) tick();
    check("rst_mem_req",   32'(bus.mem_req),   32'h0);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    check("rst_d_rvalid",  32'(bus.d_rvalid),  32'h0);
    check("rst_err",       32'(bus.err),       32'h0);
    check("rst_mem_addr",  bus.mem_addr,       32'h0);
    rst = 1'b0;

    // simultaneous requests: D first
    tick();
    check("d_issue_req",  32'(bus.mem_req), 32'h1);
    check("d_issue_addr", bus.mem_addr,     32'h100);
    check("d_issue_we",   32'(bus.mem_we),  32'h0);
    tick();
    check("d_wait_req", 32'(bus.mem_req), 32'h0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    #1;
    check("d_rvalid",   32'(bus.d_rvalid),  32'h1);
    check("d_rdata",    bus.d_rdata,        32'hDEADBEEF);
    check("d_if_quiet", 32'(bus.if_rvalid), 32'h0);
    check("d_stall_lo", 32'(bus.d_stall),   32'h0);
    check("if_stall_hi",32'(bus.if_stall),  32'h1);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b0;
    #1;
    check("arb_idle_req", 32'(bus.mem_req), 32'h0);
    tick();
    check("if_issue_req",  32'(bus.mem_req), 32'h1);
    check("if_issue_addr", bus.mem_addr,     32'h40);
    check("if_issue_we",   32'(bus.mem_we),  32'h0);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00000013;
    #1;
    check("if_rvalid", 32'(bus.if_rvalid), 32'h1);
    check("if_rdata",  bus.if_rdata,       32'h13);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b0;
    tick();

    // aging: four D grants, then IF, then D again
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h300;
    for (int g = 0; g < 6; g++) begin
      tick();
      check($sformatf("starve_grant%0d", g), bus.mem_addr, (g == 4) ? 32'h80 : 32'h300);
      tick();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'(g);
      #1;
      check($sformatf("starve_rvalid%0d", g),
            (g == 4) ? 32'(bus.if_rvalid) : 32'(bus.d_rvalid), 32'h1);
      tick();
      bus.mem_rvalid = 1'b0;
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    tick();

    // flush one cycle after the fetch issue, memory latency 3
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h44;
    tick();
    check("fl_issue_addr", bus.mem_addr, 32'h44);
    tick();
    bus.if_flush = 1'b1;
    bus.if_addr  = 32'h200;
    #1;
    check("fl_rvalid_w1", 32'(bus.if_rvalid), 32'h0);
    check("fl_stall_w1",  32'(bus.if_stall),  32'h1);
    tick();
    bus.if_flush = 1'b0;
    #1;
    check("fl_stall_w2", 32'(bus.if_stall), 32'h1);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55;
    #1;
    check("fl_rvalid_drop", 32'(bus.if_rvalid), 32'h0);
    check("fl_stall_w3",    32'(bus.if_stall),  32'h1);
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    check("fl_idle_req", 32'(bus.mem_req), 32'h0);
    tick();
    check("fl_new_req",  32'(bus.mem_req), 32'h1);
    check("fl_new_addr", bus.mem_addr,     32'h200);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h66;
    #1;
    check("fl_new_rvalid", 32'(bus.if_rvalid), 32'h1);
    check("fl_new_rdata",  bus.if_rdata,       32'h66);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b0;
    tick();

    // timeout on a store that is never acknowledged
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 32'h400;
    bus.d_wdata   = 32'hCAFEF00D;
    bus.d_be      = 4'b0011;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    check("to_issue_req",   32'(bus.mem_req),  32'h1);
    check("to_issue_we",    32'(bus.mem_we),   32'h1);
    check("to_issue_wdata", bus.mem_wdata,     32'hCAFEF00D);
    check("to_issue_be",    32'(bus.mem_be),   32'h3);
    tick();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("to_wait%0d", k), 32'(bus.d_rvalid), 32'h0);
      tick();
    end
    check("to_rvalid", 32'(bus.d_rvalid), 32'h1);
    check("to_rdata",  bus.d_rdata,       32'h0);
    check("to_err_pre",32'(bus.err),      32'h0);
    tick();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    #1;
    check("to_err_set", 32'(bus.err), 32'h1);
    bus.mem_rvalid = 1'b1;
    #1;
    check("to_late_ignored", 32'(bus.d_rvalid), 32'h0);
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    check("to_err_sticky", 32'(bus.err),     32'h1);
    check("to_no_req",     32'(bus.mem_req), 32'h0);

    // reset in WAIT followed by a late response
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h500;
    tick();
    tick();
    rst       = 1'b1;
    bus.d_req = 1'b0;
    tick();
    check("mr_err_clr", 32'(bus.err),     32'h0);
    check("mr_req",     32'(bus.mem_req), 32'h0);
    check("mr_addr",    bus.mem_addr,     32'h0);
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h77;
    #1;
    check("mr_late_d",  32'(bus.d_rvalid),  32'h0);
    check("mr_late_if", 32'(bus.if_rvalid), 32'h0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b1;
    bus.d_addr     = 32'h600;
    #1;
    check("mr_idle_req", 32'(bus.mem_req), 32'h0);
    tick();
    check("mr_new_req",  32'(bus.mem_req), 32'h1);
    check("mr_new_addr", bus.mem_addr,     32'h600);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234;
    #1;
    check("mr_new_rvalid", 32'(bus.d_rvalid), 32'h1);
    check("mr_new_rdata",  bus.d_rdata,       32'h1234);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.d_req      = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
